// File: rtl/bp_need_detect_if.sv
// ----------------------------------------------------------------------------
// bp_need_detect_if
// Stream bundle for the backpropagation-need detector.
//   s_* : sample stream in (one output neuron + label per beat)
//         s_valid, s_ready, s_out, s_label, s_last
//   m_* : per-frame result stream out
//         m_valid, m_ready, m_bp_needed, m_err_sum, m_frame_err
// Modports:
//   slave  - the detector's view (consumes s_*, produces m_*)
//   master - the surrounding pipeline's view (produces s_*, consumes m_*)
// ----------------------------------------------------------------------------
interface bp_need_detect_if #(
    parameter int DATA_W = 16,
    parameter int ERR_W  = 21
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_out;
    logic [DATA_W-1:0] s_label;
    logic              s_last;

    logic              m_valid;
    logic              m_ready;
    logic              m_bp_needed;
    logic [ERR_W-1:0]  m_err_sum;
    logic              m_frame_err;

    modport slave (
        input  s_valid, s_out, s_label, s_last, m_ready,
        output s_ready, m_valid, m_bp_needed, m_err_sum, m_frame_err
    );

    modport master (
        output s_valid, s_out, s_label, s_last, m_ready,
        input  s_ready, m_valid, m_bp_needed, m_err_sum, m_frame_err
    );
endinterface

// File: rtl/bp_need_detect.sv
// ----------------------------------------------------------------------------
// bp_need_detect
// Accumulates |output - label| over a frame of NUM_OUT beats and emits one
// result per frame: whether backpropagation is needed, the error sum and a
// framing-error flag. All outputs are registered.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous reset, active-high (1 = reset)
//   cfg_thresh - unsigned error threshold, sampled on the frame-end edge
//   bus        - bp_need_detect_if.slave: sample stream in, result stream out
// ----------------------------------------------------------------------------
module bp_need_detect #(
    parameter int DATA_W  = 16,
    parameter int NUM_OUT = 10,
    parameter int ERR_W   = DATA_W + 1 + $clog2(NUM_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ERR_W-1:0] cfg_thresh,
    bp_need_detect_if.slave  bus
);

    localparam int                CNT_W    = $clog2(NUM_OUT);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_OUT - 1);

    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] RESULT = 1'b1;

    logic [0:0]       state;
    logic [ERR_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             ready_q;
    logic             valid_q;
    logic             bp_q;
    logic             ferr_q;
    logic [ERR_W-1:0] sum_q;

    logic                     accept;
    logic                     at_last;
    logic                     frame_end;
    logic                     ferr_next;
    logic signed [DATA_W:0]   diff;
    logic        [DATA_W:0]   absd;
    logic        [ERR_W-1:0]  sum_next;

    assign bus.s_ready     = ready_q;
    assign bus.m_valid     = valid_q;
    assign bus.m_bp_needed = bp_q;
    assign bus.m_err_sum   = sum_q;
    assign bus.m_frame_err = ferr_q;

    // Handshake uses the registered ready, so s_ready never depends on
    // s_valid or m_ready combinationally.
    assign accept    = bus.s_valid & ready_q;
    assign at_last   = (cnt == LAST_CNT);
    assign frame_end = accept & (bus.s_last | at_last);
    assign ferr_next = bus.s_last ^ at_last;

    // One extra bit keeps the difference exact; negating the most negative
    // value yields 2^DATA_W, which the unsigned view of the same width holds.
    always_comb begin
        diff     = $signed({bus.s_out[DATA_W-1], bus.s_out})
                 - $signed({bus.s_label[DATA_W-1], bus.s_label});
        absd     = diff[DATA_W] ? (DATA_W+1)'(-diff) : (DATA_W+1)'(diff);
        sum_next = acc + ERR_W'(absd);
    end

    // Frame FSM: ACCUM takes beats until the frame ends, RESULT holds the
    // result until the consumer takes it. Ready comes back one cycle after
    // the result handshake, so the next frame cannot overlap the old result.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            bp_q    <= 1'b0;
            ferr_q  <= 1'b0;
            sum_q   <= '0;
        end else if (state == ACCUM) begin
            ready_q <= 1'b1;
            if (frame_end) begin
                state   <= RESULT;
                ready_q <= 1'b0;
                valid_q <= 1'b1;
                sum_q   <= sum_next;
                ferr_q  <= ferr_next;
                bp_q    <= (sum_next > cfg_thresh) | ferr_next;
                acc     <= '0;
                cnt     <= '0;
            end else if (accept) begin
                acc <= sum_next;
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            if (bus.m_ready) begin
                state   <= ACCUM;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

endmodule
